// File: rtl/data_mem_responder_pkg.sv
// +-----------------------------------------------------------------------------+
// | data_mem_responder_pkg                                                      |
// | Shared funct3 codes, FSM encoding and request decode helpers.               |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
`default_nettype none

package data_mem_responder_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam int LAT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Illegal encoding or misalignment; the range check lives in the top.
    function automatic logic req_bad(input logic we, input logic [2:0] f3, input logic [1:0] lo);
        logic illegal;
        logic misaligned;
        if (we) illegal = (f3 > F3_W);
        else    illegal = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
        case (f3)
            F3_H, F3_HU: misaligned = lo[0];
            F3_W:        misaligned = |lo;
            default:     misaligned = 1'b0;
        endcase
        return illegal || misaligned;
    endfunction

    function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [31:0] word,
                                                input logic [1:0] lo);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{lo, 3'b000} +: 8];
        h = lo[1] ? word[31:16] : word[15:0];
        case (f3)
            F3_B:    return {{24{b[7]}}, b};
            F3_BU:   return {24'd0, b};
            F3_H:    return {{16{h[15]}}, h};
            F3_HU:   return {16'd0, h};
            default: return word;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/data_mem_responder_sram.sv
// +-----------------------------------------------------------------------------+
// | mem_sram_1p                                                                 |
// | Single-port DEPTH_WORDS x 32 array, byte-enable write, synchronous read.    |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
`default_nettype none

module mem_sram_1p #(
    parameter int DEPTH_WORDS = 256,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [3:0]    be,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] r_mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) r_mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
        rdata <= r_mem[addr];
    end

endmodule

`default_nettype wire

// File: rtl/data_mem_responder.sv
// +-----------------------------------------------------------------------------+
// | data_mem_responder                                                          |
// | Valid/ready data-memory responder with RV32I sizing and wait states.        |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
`default_nettype none

module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int          AW      = $clog2(DEPTH_WORDS);
    localparam logic [32:0] c_LIMIT = 33'(4 * DEPTH_WORDS);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [LAT_W-1:0] r_cnt;
    logic [LAT_W-1:0] w_cnt_nxt;
    logic             r_we;
    logic [2:0]       r_f3;
    logic [31:0]      r_addr;
    logic [31:0]      r_wdata;

    logic             w_accept;
    logic             w_do_access;
    logic             w_rsp_done;
    logic             w_err;
    logic [3:0]       w_be;
    logic [31:0]      w_wdata_lane;
    logic [AW-1:0]    w_sram_addr;
    logic [31:0]      w_sram_rdata;

    assign req_ready  = (r_state == ST_IDLE);
    assign w_accept   = req_valid && req_ready;
    assign w_rsp_done = (r_state == ST_RESP) && rsp_ready;
    assign w_err      = ({1'b0, r_addr} >= c_LIMIT) || req_bad(r_we, r_f3, r_addr[1:0]);

    // The read is launched on the accept edge from the live address so that a
    // zero-wait-state request still has its word ready one edge later.
    assign w_sram_addr = (r_state == ST_IDLE) ? req_addr[2 +: AW] : r_addr[2 +: AW];

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_do_access = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = ST_WAIT;
                    w_cnt_nxt   = LAT_W'(LATENCY);
                end
            end
            ST_WAIT: begin
                if (r_cnt == '0) begin
                    w_state_nxt = ST_RESP;
                    w_do_access = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            ST_RESP: begin
                if (rsp_ready) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_be         = 4'b0000;
        w_wdata_lane = '0;
        case (r_f3)
            F3_B: begin
                w_be         = 4'b0001 << r_addr[1:0];
                w_wdata_lane = {4{r_wdata[7:0]}};
            end
            F3_H: begin
                w_be         = r_addr[1] ? 4'b1100 : 4'b0011;
                w_wdata_lane = {2{r_wdata[15:0]}};
            end
            default: begin
                w_be         = 4'b1111;
                w_wdata_lane = r_wdata;
            end
        endcase
    end

    mem_sram_1p #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_sram (
        .clk   (clk),
        .we    (w_do_access && r_we && !w_err),
        .be    (w_be),
        .addr  (w_sram_addr),
        .wdata (w_wdata_lane),
        .rdata (w_sram_rdata)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_we      <= 1'b0;
            r_f3      <= '0;
            r_addr    <= '0;
            r_wdata   <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_accept) begin
                r_we    <= req_we;
                r_f3    <= req_funct3;
                r_addr  <= req_addr;
                r_wdata <= req_wdata;
            end
            if (w_do_access) begin
                rsp_valid <= 1'b1;
                rsp_err   <= w_err;
                rsp_rdata <= (w_err || r_we) ? 32'd0
                                             : load_extend(r_f3, w_sram_rdata, r_addr[1:0]);
            end else if (w_rsp_done) begin
                rsp_valid <= 1'b0;
                rsp_err   <= 1'b0;
                rsp_rdata <= '0;
            end
        end
    end

endmodule

`default_nettype wire
